ipg_req_tx_inserter: RTL and testbench

- Sits on the TX side of the 10G MAC+PHY, between the 64b/66b encoder output and the gearbox/serdes.
- Carries single-beat memory read/write requests inside inter-packet gaps by overwriting pure idle control blocks with request-tagged idle blocks.
- Is the transmit-side counterpart of the RX-side IPG request extractor; Ethernet frames pass through bit-exact.

---
 rtl/ipg_req_tx_inserter.sv | 156 +++++++++++++++
 tb/tb_ipg_req_tx_inserter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipg_req_tx_inserter.sv
// TX-side IPG request inserter: replaces pure idle control blocks with request-tagged
// idle blocks carrying single-beat read/write requests; all other blocks pass bit-exact.
module ipg_req_tx_inserter #(
    parameter int ADDR_WIDTH = 40,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           in_data,
    input  logic [1:0]            in_hdr,
    input  logic                  in_valid,
    output logic [63:0]           out_data,
    output logic [1:0]            out_hdr,
    output logic                  out_valid,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [7:0]            req_id,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    output logic                  req_done,
    output logic [CNT_WIDTH-1:0]  stat_abort_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_W1    = 2'd2;
    localparam logic [1:0] ST_W2    = 2'd3;

    localparam logic [1:0] HDR_CTRL = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [7:0] IDLE_BT  = 8'h1E;

    logic [1:0]            state_q, state_d;
    logic                  ready_q, ready_d;
    logic [63:0]           out_data_q, out_data_d;
    logic [1:0]            out_hdr_q, out_hdr_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic [1:0]            op_q;
    logic [7:0]            id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [63:0]           wdata_q;

    logic                  accept;
    logic                  op_ok;
    logic                  in_idle;
    logic [63:0]           head_blk;
    logic [63:0]           cont1_blk;
    logic [63:0]           cont2_blk;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept    = req_valid && ready_q;
    assign op_ok     = (req_op == OP_READ) || (req_op == OP_WRITE);
    assign in_idle   = (in_hdr == HDR_CTRL) && (in_data[7:0] == IDLE_BT) && (in_data[63:8] == 56'd0);

    // The block format fixes the address field at 40 bits.
    assign head_blk  = {2'b01, op_q, id_q, 4'h0, addr_q[39:0], IDLE_BT};
    assign cont1_blk = {2'b10, wdata_q[53:0], IDLE_BT};
    assign cont2_blk = {2'b10, 44'd0, wdata_q[63:54], IDLE_BT};

    always_comb begin
        state_d     = state_q;
        out_data_d  = in_data;
        out_hdr_d   = in_hdr;
        out_valid_d = in_valid;
        done_d      = 1'b0;
        cnt_d       = cnt_q;

        if (in_valid) begin
            case (state_q)
                ST_WAIT: begin
                    if (in_idle) begin
                        out_data_d = head_blk;
                        if (op_q == OP_READ) begin
                            done_d  = 1'b1;
                            state_d = ST_EMPTY;
                        end else begin
                            state_d = ST_W1;
                        end
                    end
                end
                ST_W1: begin
                    if (in_idle) begin
                        out_data_d = cont1_blk;
                        state_d    = ST_W2;
                    end else begin
                        cnt_d   = sat_inc(cnt_q);
                        state_d = ST_WAIT;
                    end
                end
                ST_W2: begin
                    if (in_idle) begin
                        out_data_d = cont2_blk;
                        done_d     = 1'b1;
                        state_d    = ST_EMPTY;
                    end else begin
                        cnt_d   = sat_inc(cnt_q);
                        state_d = ST_WAIT;
                    end
                end
                default: ;
            endcase
        end

        // Reserved ops are taken off the interface but never scheduled.
        if (accept && op_ok) begin
            state_d = ST_WAIT;
        end

        ready_d = (state_d == ST_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            ready_q     <= 1'b1;
            out_data_q  <= 64'd0;
            out_hdr_q   <= 2'b00;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            out_data_q  <= out_data_d;
            out_hdr_q   <= out_hdr_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= req_op;
            id_q    <= req_id;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    assign out_data         = out_data_q;
    assign out_hdr          = out_hdr_q;
    assign out_valid        = out_valid_q;
    assign req_ready        = ready_q;
    assign req_done         = done_q;
    assign stat_abort_count = cnt_q;

endmodule

// File: tb/tb_ipg_req_tx_inserter.sv
// Bench for ipg_req_tx_inserter: directed scenarios plus randomized traffic against a
// request-level model (held request + number of blocks already sent).
module tb_ipg_req_tx_inserter;

    localparam int CW = 3;
    localparam logic [63:0] IDLE = 64'h0000_0000_0000_001E;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [63:0]    in_data = '0;
    logic [1:0]     in_hdr = 2'b10;
    logic           in_valid = 1'b0;
    logic [63:0]    out_data;
    logic [1:0]     out_hdr;
    logic           out_valid;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [1:0]     req_op = '0;
    logic [7:0]     req_id = '0;
    logic [39:0]    req_addr = '0;
    logic [63:0]    req_wdata = '0;
    logic           req_done;
    logic [CW-1:0]  stat_abort_count;

    ipg_req_tx_inserter #(.ADDR_WIDTH(40), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_hdr(in_hdr), .in_valid(in_valid),
        .out_data(out_data), .out_hdr(out_hdr), .out_valid(out_valid),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_id(req_id), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .stat_abort_count(stat_abort_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one held request and how many of its blocks went out this attempt.
    bit          m_held;
    logic [1:0]  m_op;
    logic [7:0]  m_id;
    logic [39:0] m_addr;
    logic [63:0] m_wdata;
    int          m_sent;
    int          m_cnt;

    logic [63:0]   exp_data;
    logic [1:0]    exp_hdr;
    logic          exp_valid, exp_done, exp_ready;
    logic [CW-1:0] exp_cnt;

    function automatic bit is_idle(input logic [1:0] h, input logic [63:0] d);
        return (h == 2'b01) && (d == IDLE);
    endfunction

    function automatic logic [63:0] blk(input int k);
        case (k)
            0:       return {2'b01, m_op, m_id, 4'h0, m_addr, 8'h1E};
            1:       return {2'b10, m_wdata[53:0], 8'h1E};
            default: return {2'b10, 44'd0, m_wdata[63:54], 8'h1E};
        endcase
    endfunction

    task automatic model_reset();
        m_held = 0; m_sent = 0; m_cnt = 0;
    endtask

    // Predicts the outputs for the current inputs, advances the model, then clocks the DUT.
    task automatic step();
        bit pre_ready;
        int need;
        pre_ready = !m_held;
        exp_valid = in_valid; exp_data = in_data; exp_hdr = in_hdr; exp_done = 0;
        if (in_valid && m_held) begin
            need = (m_op == 2'b01) ? 1 : 3;
            if (is_idle(in_hdr, in_data)) begin
                exp_data = blk(m_sent);
                m_sent++;
                if (m_sent == need) begin
                    exp_done = 1; m_held = 0; m_sent = 0;
                end
            end else if (m_sent > 0) begin
                m_cnt  = (m_cnt < (2**CW - 1)) ? m_cnt + 1 : m_cnt;
                m_sent = 0;
            end
        end
        if (pre_ready && req_valid && (req_op == 2'b01 || req_op == 2'b10)) begin
            m_held = 1; m_sent = 0;
            m_op = req_op; m_id = req_id; m_addr = req_addr; m_wdata = req_wdata;
        end
        exp_ready = !m_held;
        exp_cnt   = CW'(m_cnt);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] h, input logic [63:0] d, input logic v);
        in_hdr = h; in_data = d; in_valid = v;
    endtask

    task automatic offer(input logic [1:0] op, input logic [7:0] id, input logic [39:0] a,
                         input logic [63:0] w);
        req_valid = 1; req_op = op; req_id = id; req_addr = a; req_wdata = w;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, {$urandom, $urandom}, 1'b1);
            req_valid = 1'b1;
            @(posedge clk); #1;
            n_vec++;
            if ({out_data, out_hdr, out_valid, req_ready, req_done, stat_abort_count} !==
                {64'd0, 2'b00, 1'b0, 1'b1, 1'b0, {CW{1'b0}}}) begin
                n_err++;
                $display("FAIL reset: got data=%h hdr=%b v=%b rdy=%b done=%b cnt=%0d, want zeros rdy=1",
                         out_data, out_hdr, out_valid, req_ready, req_done, stat_abort_count);
            end
        end
        req_valid = 1'b0;
        rst_n = 1;
    endtask

    task automatic test_passthrough();
        logic [63:0] pd [6];
        logic [1:0]  ph [6];
        pd[0] = 64'h0123_4567_89AB_CDEF; ph[0] = 2'b10;
        pd[1] = 64'hD555_5555_5555_55FB; ph[1] = 2'b01;
        pd[2] = 64'h4000_0000_0000_001E; ph[2] = 2'b01;
        pd[3] = 64'hFFFF_FFFF_FFFF_FFFF; ph[3] = 2'b10;
        pd[4] = 64'h0000_0000_0000_0087; ph[4] = 2'b01;
        pd[5] = IDLE;                    ph[5] = 2'b10;
        offer(2'b01, 8'h11, 40'h1, 64'h0);
        for (int i = 0; i < 6; i++) begin
            drive(ph[i], pd[i], 1'b1);
            if (i == 1) req_valid = 1'b0;
            step();
            n_vec++;
            if ({out_hdr, out_data, out_valid} !== {ph[i], pd[i], 1'b1}) begin
                n_err++;
                $display("FAIL passthrough[%0d]: got %b/%h v=%b, want %b/%h v=1",
                         i, out_hdr, out_data, out_valid, ph[i], pd[i]);
            end
        end
        // The read offered above is still held; let it drain through an idle.
        drive(2'b01, IDLE, 1'b1);
        step();
    endtask

    task automatic test_read();
        int dones = 0;
        offer(2'b01, 8'hAD, 40'hDD_ADDA_DDAD, 64'h0);
        drive(2'b10, 64'h5555_AAAA_5555_AAAA, 1'b1);
        step();
        req_valid = 0;
        n_vec++;
        if (out_data !== 64'h5555_AAAA_5555_AAAA || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL read_accept: got data=%h rdy=%b, want data=5555aaaa5555aaaa rdy=0", out_data, req_ready);
        end
        drive(2'b01, IDLE, 1'b1);
        step();
        n_vec++;
        if ({out_hdr, out_data, req_done} !== {2'b01, 64'h5AD0_DDAD_DADD_AD1E, 1'b1}) begin
            n_err++;
            $display("FAIL read_head: got %b/%h done=%b, want 01/5ad0ddaddaddad1e done=1", out_hdr, out_data, req_done);
        end
        step();
        n_vec++;
        if ({out_data, req_done, req_ready} !== {IDLE, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL read_after: got data=%h done=%b rdy=%b, want idle done=0 rdy=1", out_data, req_done, req_ready);
        end
        dones = int'(req_done);
    endtask

    task automatic test_write();
        logic [63:0] want [3];
        int dones = 0;
        want[0] = 64'h65A0_0123_4567_891E;
        want[1] = 64'hBFFF_FFFF_FFFF_FF1E;
        want[2] = 64'h8000_0000_0003_FF1E;
        offer(2'b10, 8'h5A, 40'h01_2345_6789, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(2'b10, 64'h0, 1'b1);
        step();
        req_valid = 0;
        drive(2'b01, IDLE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            dones += int'(req_done);
            n_vec++;
            if ({out_hdr, out_data} !== {2'b01, want[i]}) begin
                n_err++;
                $display("FAIL write_blk%0d: got %b/%h, want 01/%h", i, out_hdr, out_data, want[i]);
            end
        end
        step();
        dones += int'(req_done);
        n_vec++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL write_done_count: got %0d pulses, want 1", dones);
        end
    endtask

    task automatic test_abort();
        offer(2'b10, 8'h3C, 40'hAB_CDEF_0123, {$urandom, $urandom});
        drive(2'b10, 64'h0, 1'b1);
        step();
        req_valid = 0;
        drive(2'b01, IDLE, 1'b1);
        step();
        drive(2'b01, 64'h0000_0000_0000_00FB, 1'b1);
        step();
        n_vec++;
        if ({out_data, stat_abort_count, req_done} !== {64'h0000_0000_0000_00FB, CW'(1), 1'b0}) begin
            n_err++;
            $display("FAIL abort_start: got data=%h cnt=%0d done=%b, want start block cnt=1 done=0",
                     out_data, stat_abort_count, req_done);
        end
        drive(2'b01, IDLE, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if ({out_data, req_done} !== {exp_data, exp_done} || out_data !== blk(i)) begin
                n_err++;
                $display("FAIL abort_resend%0d: got %h done=%b, want %h done=%b", i, out_data, req_done, exp_data, exp_done);
            end
        end
    endtask

    task automatic test_pause();
        offer(2'b10, 8'h77, 40'h00_0000_1000, 64'h0123_4567_89AB_CDEF);
        drive(2'b10, 64'h0, 1'b1);
        step();
        req_valid = 0;
        drive(2'b01, IDLE, 1'b1);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(2'b01, IDLE, 1'b0);
            step();
            n_vec++;
            if ({out_valid, out_data, req_done} !== {1'b0, IDLE, 1'b0}) begin
                n_err++;
                $display("FAIL pause%0d: got v=%b data=%h done=%b, want v=0 idle done=0", i, out_valid, out_data, req_done);
            end
        end
        drive(2'b01, IDLE, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if ({out_valid, out_data, req_done} !== {1'b1, exp_data, exp_done}) begin
                n_err++;
                $display("FAIL pause_resume%0d: got v=%b %h done=%b, want v=1 %h done=%b",
                         i, out_valid, out_data, req_done, exp_data, exp_done);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        offer(2'b10, 8'h99, 40'h12_3456_789A, 64'hCAFE_F00D_DEAD_BEEF);
        drive(2'b10, 64'h0, 1'b1);
        step();
        req_valid = 0;
        drive(2'b01, IDLE, 1'b1);
        step();
        step();
        rst_n = 0;
        model_reset();
        #1;
        n_vec++;
        if ({out_data, out_hdr, out_valid, req_ready, req_done, stat_abort_count} !==
            {64'd0, 2'b00, 1'b0, 1'b1, 1'b0, {CW{1'b0}}}) begin
            n_err++;
            $display("FAIL rst_mid: got data=%h hdr=%b v=%b rdy=%b done=%b cnt=%0d, want zeros rdy=1",
                     out_data, out_hdr, out_valid, req_ready, req_done, stat_abort_count);
        end
        @(posedge clk); #1;
        rst_n = 1;
        step();
        n_vec++;
        if ({out_data, req_done, req_ready, stat_abort_count} !== {IDLE, 1'b0, 1'b1, {CW{1'b0}}}) begin
            n_err++;
            $display("FAIL rst_mid_after: got data=%h done=%b rdy=%b cnt=%0d, want idle done=0 rdy=1 cnt=0",
                     out_data, req_done, req_ready, stat_abort_count);
        end
    endtask

    task automatic test_saturate();
        offer(2'b10, 8'h01, 40'h0, 64'h0);
        drive(2'b10, 64'h0, 1'b1);
        step();
        req_valid = 0;
        for (int i = 0; i < 9; i++) begin
            drive(2'b01, IDLE, 1'b1);
            step();
            drive(2'b10, 64'h1, 1'b1);
            step();
        end
        n_vec++;
        if (stat_abort_count !== {CW{1'b1}}) begin
            n_err++;
            $display("FAIL saturate: got cnt=%0d, want %0d", stat_abort_count, 2**CW - 1);
        end
        drive(2'b01, IDLE, 1'b1);
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_random();
        int r;
        for (int c = 0; c < 2000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      drive(2'b01, IDLE, 1'b1);
            else if (r < 70) drive(2'b10, {$urandom, $urandom}, 1'b1);
            else if (r < 80) drive(2'b01, {$urandom, 24'h0, 8'h78}, 1'b1);
            else if (r < 88) drive(2'b01, {$urandom_range(1, 255), 48'h0, 8'h1E}, 1'b1);
            else             drive(2'b01, IDLE, 1'b0);
            req_valid = ($urandom_range(0, 9) < 4);
            req_op    = 2'($urandom);
            req_id    = 8'($urandom);
            req_addr  = {8'($urandom), 32'($urandom)};
            req_wdata = {$urandom, $urandom};
            step();
            n_vec++;
            if ({out_hdr, out_data, out_valid, req_done, req_ready, stat_abort_count} !==
                {exp_hdr, exp_data, exp_valid, exp_done, exp_ready, exp_cnt}) begin
                n_err++;
                $display("FAIL random[%0d]: got %b/%h v=%b done=%b rdy=%b cnt=%0d, want %b/%h v=%b done=%b rdy=%b cnt=%0d",
                         c, out_hdr, out_data, out_valid, req_done, req_ready, stat_abort_count,
                         exp_hdr, exp_data, exp_valid, exp_done, exp_ready, exp_cnt);
            end
        end
        req_valid = 0;
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_passthrough();
        test_read();
        test_write();
        test_abort();
        test_pause();
        test_reset_mid_write();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
